uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver that deserialises the host serial line into bytes.
- Feeds the bootloader's `rx_data`/`rx_done` inputs, so the ROM image loads byte-by-byte into RAM.
- Uses 16x oversampling with mid-bit sampling.
- Rejects start-bit glitches and flags framing errors without producing a byte.

Parameters:
- `CLK_HZ`, 50000000, system clock frequency in Hz.
- `BAUD`, 115200, line rate in bits/s.
- `OVERSAMPLE`, 16, sample ticks per bit. Must be an even number ≥ 4.

Ports:
- `clk`  input  1  system clock. All logic is on its rising edge.
- `rst_n`  input  1  synchronous reset, active-low.
- `rx`  input  1  asynchronous serial line. Idle level is high.
- `rx_data`  output  8  last correctly framed byte.
- `rx_done`  output  1  one-cycle pulse when `rx_data` updates.
- `frame_err`  output  1  one-cycle pulse when the stop bit is sampled low.
- `busy`  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset: when `rst_n` is sampled low on a clk edge, all of the following take effect.
  - `rx_data`=0, `rx_done`=0, `frame_err`=0, `busy`=0.
  - Synchroniser flops = 1, tick counter = 0, sample counter = 0, bit index = 0, state = IDLE.
- Reset mid-frame aborts the frame: no `rx_done`, no `frame_err`.
- Synchroniser: `rx` passes through two flops to give `rx_s`. Only `rx_s` is used internally.
- Tick generator:
  - `DIV = (CLK_HZ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE)`, integer division, clamped to ≥1.
  - Counter counts 0..DIV-1; `tick` is high for one cycle when the count equals DIV-1.
  - Counter is held at 0 in IDLE, so sample phase is aligned to the detected start edge.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: if `rx_s`==0 → START, sample counter = 0.
  - START: on each tick, sample counter += 1. On the tick where it reaches `OVERSAMPLE/2` (mid-bit):
    - `rx_s`==0 → DATA, counter = 0, bit index = 0.
    - `rx_s`==1 → IDLE (glitch rejected, no output).
  - DATA: on each tick, counter += 1. On reaching `OVERSAMPLE`:
    - Right-shift `rx_s` into bit 7 of the shift register (LSB first on the line).
    - Counter = 0, bit index += 1.
    - After the 8th bit → STOP.
  - STOP: on reaching `OVERSAMPLE` ticks:
    - `rx_s`==1 → `rx_data` <= shift register, `rx_done`=1 for exactly one cycle, → IDLE.
    - `rx_s`==0 → `frame_err`=1 for one cycle, `rx_data` unchanged, → WAIT_HIGH.
  - WAIT_HIGH: stays until `rx_s`==1, then → IDLE. Covers break conditions: no new start is detected while the line is held low.
- `rx_done` and `frame_err` are never high in the same cycle.
- `rx_data` is stable between `rx_done` pulses. Consumers may read it at any time after the pulse.
- Back-to-back frames: IDLE is re-entered at the stop-bit midpoint. The next start edge, arriving half a bit later, is detected normally.
- Latency with DIV=1, OVERSAMPLE=16: the `rx_done` pulse is high on clock 155 after the clock edge at which `rx` is first sampled low. Breakdown: 2 synchroniser + 1 detect + 8 start + 128 data + 16 stop.
- Counter widths are sized by `$clog2` of DIV and OVERSAMPLE. Counters never wrap within a frame.

Test Plan:
- All scenarios except 6 use `CLK_HZ`=1600000, `BAUD`=100000 (DIV=1, 16 clocks/bit).
1. Send 0xA5 after ≥2 idle bit times → `rx_done` pulses one cycle, 155 clocks after the start edge. `rx_data`=0xA5, `frame_err`=0, `busy` low the cycle after.
2. Send 0x00 then 0xFF with no inter-frame gap → two `rx_done` pulses 160 clocks apart. `rx_data` reads 0x00, then 0xFF.
3. Drive `rx` low for 4 clocks, then high → no `rx_done` or `frame_err`. `busy` is high for ≤10 cycles, then 0.
4. Send 0x3C with the stop bit low, hold `rx` low 20 bit times, release, then send 0x42:
   - `frame_err` pulses once and `rx_data` stays 0xA5.
   - No start is detected before release.
   - 0x42 is then received with `rx_done`.
5. Drop `rst_n` for one cycle during data bit 4 of 0xF0 → all outputs 0, no pulse for that frame. After rx idles ≥1 bit time, 0x81 is received correctly.
6. Defaults (50 MHz, 115200, DIV=27): send 0x55 at the exact bit period, then at +2% and −2% baud error → `rx_data`=0x55 with `rx_done` in all three cases.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 16x oversampling and mid-bit sampling.
// The line is double-flopped, a start edge aligns the sample phase, start-bit
// glitches are rejected at the start-bit midpoint, and a low stop bit raises a
// framing-error pulse instead of delivering a byte.
module uart_rx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy
);

  // Clocks per oversample tick, rounded to nearest and never below one.
  localparam int DIV_RAW = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] MID_LAST  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] BIT_LAST  = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t          state_r;
  logic [1:0]      sync_r;
  logic            rx_s;
  logic [TW-1:0]   tick_cnt_r;
  logic            tick_s;
  logic [SW-1:0]   sample_cnt_r;
  logic [2:0]      bit_idx_r;
  logic [7:0]      shift_r;
  logic [7:0]      rx_data_r;
  logic            rx_done_r;
  logic            frame_err_r;
  logic            busy_r;

  assign rx_s      = sync_r[1];
  assign tick_s    = (tick_cnt_r == TICK_LAST);
  assign rx_data   = rx_data_r;
  assign rx_done   = rx_done_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rx};
    end
  end

  // Oversample tick divider, held at zero in IDLE so sampling is phase-aligned to the start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt_r <= {TW{1'b0}};
    end else if (state_r == IDLE) begin
      tick_cnt_r <= {TW{1'b0}};
    end else if (tick_s) begin
      tick_cnt_r <= {TW{1'b0}};
    end else begin
      tick_cnt_r <= tick_cnt_r + TW'(1);
    end
  end

  // Receive FSM with registered byte, strobes and busy flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      sample_cnt_r <= {SW{1'b0}};
      bit_idx_r    <= 3'd0;
      shift_r      <= 8'h00;
      rx_data_r    <= 8'h00;
      rx_done_r    <= 1'b0;
      frame_err_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      rx_done_r   <= 1'b0;
      frame_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          sample_cnt_r <= {SW{1'b0}};
          bit_idx_r    <= 3'd0;
          if (!rx_s) begin
            state_r <= START;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        START: begin
          if (tick_s) begin
            if (sample_cnt_r == MID_LAST) begin
              sample_cnt_r <= {SW{1'b0}};
              bit_idx_r    <= 3'd0;
              if (!rx_s) begin
                state_r <= DATA;
              end else begin
                // Line went back high before mid-bit: treat as a glitch.
                state_r <= IDLE;
                busy_r  <= 1'b0;
              end
            end else begin
              sample_cnt_r <= sample_cnt_r + SW'(1);
            end
          end
        end
        DATA: begin
          if (tick_s) begin
            if (sample_cnt_r == BIT_LAST) begin
              sample_cnt_r <= {SW{1'b0}};
              shift_r      <= {rx_s, shift_r[7:1]};
              bit_idx_r    <= bit_idx_r + 3'd1;
              if (bit_idx_r == 3'd7) begin
                state_r <= STOP;
              end
            end else begin
              sample_cnt_r <= sample_cnt_r + SW'(1);
            end
          end
        end
        STOP: begin
          if (tick_s) begin
            if (sample_cnt_r == BIT_LAST) begin
              sample_cnt_r <= {SW{1'b0}};
              if (rx_s) begin
                rx_data_r <= shift_r;
                rx_done_r <= 1'b1;
                state_r   <= IDLE;
                busy_r    <= 1'b0;
              end else begin
                frame_err_r <= 1'b1;
                state_r     <= WAIT_HIGH;
              end
            end else begin
              sample_cnt_r <= sample_cnt_r + SW'(1);
            end
          end
        end
        WAIT_HIGH: begin
          // A held-low line (break) must not be mistaken for a new start bit.
          if (rx_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r      <= IDLE;
          sample_cnt_r <= {SW{1'b0}};
          bit_idx_r    <= 3'd0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard testbench for uart_rx: instance a runs at DIV=1 (16 clocks/bit),
// instance b uses the default 50 MHz / 115200 parameters.
module tb_uart_rx;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       rx_a, rx_b;
  logic [7:0] rx_data_a, rx_data_b;
  logic       rx_done_a, rx_done_b;
  logic       frame_err_a, frame_err_b;
  logic       busy_a, busy_b;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic [7:0] last_good_a = 8'h00;
  logic [7:0] last_good_b = 8'h00;
  int   exp_ferr_a = 0;
  int   seen_ferr_a = 0;
  int   seen_ferr_b = 0;
  logic prev_done_a = 1'b0;
  logic prev_done_b = 1'b0;
  logic busy_chk_a = 1'b0;

  uart_rx #(.CLK_HZ(1600000), .BAUD(100000), .OVERSAMPLE(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .rx_data(rx_data_a),
    .rx_done(rx_done_a), .frame_err(frame_err_a), .busy(busy_a)
  );

  uart_rx dut_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b), .rx_data(rx_data_b),
    .rx_done(rx_done_b), .frame_err(frame_err_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: pops expected bytes whenever a DUT strobes an output.
  always @(negedge clk) begin
    exp_t e;
    if (busy_chk_a) begin
      check("busy_after_done_a", busy_a, 1'b0);
      busy_chk_a = 1'b0;
    end
    if (rx_done_a) begin
      check("done_ferr_excl_a", frame_err_a, 1'b0);
      check("done_width_a", prev_done_a, 1'b0);
      if (q_a.size() == 0) begin
        check("unexpected_done_a", rx_done_a, 1'b0);
      end else begin
        e = q_a.pop_front();
        check("rx_data_a", rx_data_a, e.data);
        if (e.cyc >= 0) check("done_latency_a", cyc, e.cyc);
        last_good_a = e.data;
      end
      busy_chk_a = 1'b1;
    end
    if (frame_err_a) begin
      seen_ferr_a++;
      check("ferr_data_kept_a", rx_data_a, last_good_a);
    end
    prev_done_a = rx_done_a;

    if (rx_done_b) begin
      check("done_ferr_excl_b", frame_err_b, 1'b0);
      check("done_width_b", prev_done_b, 1'b0);
      if (q_b.size() == 0) begin
        check("unexpected_done_b", rx_done_b, 1'b0);
      end else begin
        e = q_b.pop_front();
        check("rx_data_b", rx_data_b, e.data);
        last_good_b = e.data;
      end
    end
    if (frame_err_b) begin
      seen_ferr_b++;
      check("ferr_data_kept_b", rx_data_b, last_good_b);
    end
    prev_done_b = rx_done_b;
  end

  // Drive one 8N1 frame starting at a negedge; rst_bit >= 0 pulses reset mid-way through that frame bit.
  task automatic send_frame(input bit dut, input logic [7:0] b, input bit stop_hi,
                            input int period, input int rst_bit);
    logic [9:0] bits;
    exp_t       e;
    bits = {stop_hi, b, 1'b0};
    if (stop_hi && rst_bit < 0) begin
      e.data = b;
      e.cyc  = dut ? -1 : cyc + 155;
      if (dut) q_b.push_back(e); else q_a.push_back(e);
    end
    if (!stop_hi && !dut) exp_ferr_a++;
    for (int i = 0; i < 10; i++) begin
      if (dut) rx_b = bits[i]; else rx_a = bits[i];
      if (i == rst_bit) begin
        repeat (period / 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midframe_rst_data", rx_data_a, 8'h00);
        check("midframe_rst_done", rx_done_a, 1'b0);
        check("midframe_rst_ferr", frame_err_a, 1'b0);
        check("midframe_rst_busy", busy_a, 1'b0);
        last_good_a = 8'h00;
        rst_n = 1'b1;
        repeat (period - period / 2 - 1) @(negedge clk);
      end else begin
        repeat (period) @(negedge clk);
      end
    end
  endtask

  initial begin
    int busy_cnt;
    rst_n = 1'b0;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data", rx_data_a, 8'h00);
    check("reset_rx_done", rx_done_a, 1'b0);
    check("reset_frame_err", frame_err_a, 1'b0);
    check("reset_busy", busy_a, 1'b0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    // 1: single byte after idle
    send_frame(1'b0, 8'hA5, 1'b1, 16, -1);
    repeat (32) @(negedge clk);

    // 2: back-to-back 0x00 then 0xFF
    send_frame(1'b0, 8'h00, 1'b1, 16, -1);
    send_frame(1'b0, 8'hFF, 1'b1, 16, -1);
    repeat (32) @(negedge clk);

    // 3: 4-clock start glitch
    rx_a = 1'b0;
    repeat (4) @(negedge clk);
    rx_a = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy_a) busy_cnt++;
      @(negedge clk);
    end
    check("glitch_busy_seen", (busy_cnt > 0), 1'b1);
    check("glitch_busy_le10", (busy_cnt <= 10), 1'b1);
    check("glitch_busy_end", busy_a, 1'b0);

    // 4: framing error, break held low, release, then a good byte
    send_frame(1'b0, 8'hA5, 1'b1, 16, -1);
    repeat (32) @(negedge clk);
    send_frame(1'b0, 8'h3C, 1'b0, 16, -1);
    repeat (10 * 16) @(negedge clk);
    check("break_busy_held", busy_a, 1'b1);
    repeat (9 * 16) @(negedge clk);
    rx_a = 1'b1;
    repeat (32) @(negedge clk);
    check("break_released_idle", busy_a, 1'b0);
    send_frame(1'b0, 8'h42, 1'b1, 16, -1);
    repeat (32) @(negedge clk);

    // 5: reset during data bit 4 of 0xF0, then 0x81
    send_frame(1'b0, 8'hF0, 1'b1, 16, 5);
    repeat (32) @(negedge clk);
    send_frame(1'b0, 8'h81, 1'b1, 16, -1);
    repeat (32) @(negedge clk);

    // 6: default parameters, exact / +2% / -2% bit period
    send_frame(1'b1, 8'h55, 1'b1, 434, -1);
    repeat (900) @(negedge clk);
    send_frame(1'b1, 8'h55, 1'b1, 425, -1);
    repeat (900) @(negedge clk);
    send_frame(1'b1, 8'h55, 1'b1, 443, -1);
    repeat (900) @(negedge clk);

    for (int i = 0; i < 2000 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
    check("pending_a", q_a.size(), 0);
    check("pending_b", q_b.size(), 0);
    check("frame_err_count_a", seen_ferr_a, exp_ferr_a);
    check("frame_err_count_b", seen_ferr_b, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
